// File: rtl/simon_pkg.sv
// Shared types and constants for the Simon Says pattern player.
package simon_pkg;

    localparam int NUM_LEDS = 4;

    // Colour codes double as LED bit indices.
    localparam logic [1:0] GREEN  = 2'd0;
    localparam logic [1:0] RED    = 2'd1;
    localparam logic [1:0] YELLOW = 2'd2;
    localparam logic [1:0] BLUE   = 2'd3;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        ON   = 3'd2,
        GAP  = 3'd3,
        DONE = 3'd4
    } state_t;

    // Map a colour code to its one-hot LED vector.
    function automatic logic [NUM_LEDS-1:0] colour_one_hot(input logic [1:0] colour);
        return NUM_LEDS'(1) << colour;
    endfunction

endpackage

// File: rtl/simon_sequence_player_phase_timer.sv
// Terminal-count cycle timer shared by the LED-on and gap phases.
// Counts 0..i_Terminal while enabled; o_Expired flags the terminal cycle and
// the count reloads to 0 on that same edge, so it never wraps.
module phase_timer #(
    parameter int W = 2
) (
    input  logic         i_Clk,
    input  logic         i_Reset,
    input  logic         i_Clear,
    input  logic         i_Enable,
    input  logic [W-1:0] i_Terminal,
    output logic         o_Expired
);

    logic [W-1:0] count_q;

    assign o_Expired = i_Enable && (count_q == i_Terminal);

    // Count up while enabled; clear or terminal match reloads zero.
    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            count_q <= '0;
        end else if (i_Clear || o_Expired) begin
            count_q <= '0;
        end else if (i_Enable) begin
            count_q <= count_q + W'(1);
        end
    end

endmodule

// File: rtl/simon_sequence_player.sv
// Plays a stored Simon Says colour pattern on four LEDs with timed on/gap
// phases. Outputs are registered from the current state, so they trail the
// state register by one cycle; an abort clears them on the abort edge itself.
module simon_sequence_player
    import simon_pkg::*;
#(
    parameter int MAX_LEN  = 16,
    parameter int CLKS_ON  = 12500000,
    parameter int CLKS_GAP = 2500000,
    localparam int STEP_W  = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1,
    localparam int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic                i_Clk,
    input  logic                i_Reset,
    input  logic                i_Wr_En,
    input  logic [STEP_W-1:0]   i_Wr_Addr,
    input  logic [1:0]          i_Wr_Data,
    input  logic [LEN_W-1:0]    i_Length,
    input  logic                i_Start,
    input  logic                i_Abort,
    output logic [NUM_LEDS-1:0] o_LED,
    output logic                o_Busy,
    output logic                o_Done,
    output state_t              o_State   // debug view of the FSM state
);

    localparam int TMR_MAX = (CLKS_ON > CLKS_GAP) ? CLKS_ON : CLKS_GAP;
    localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

    localparam logic [TMR_W-1:0] ON_TERM  = TMR_W'(CLKS_ON - 1);
    localparam logic [TMR_W-1:0] GAP_TERM = TMR_W'(CLKS_GAP - 1);

    state_t              state_q, state_d;
    logic [LEN_W-1:0]    len_q;
    logic [STEP_W-1:0]   step_q;
    logic [1:0]          pattern [MAX_LEN];

    logic                tmr_clear, tmr_en, tmr_expired;
    logic [TMR_W-1:0]    tmr_term;
    logic                load_len, step_inc;
    logic                abort_now, last_step;
    logic [LEN_W-1:0]    len_clamped;
    logic [NUM_LEDS-1:0] led_d;
    logic                busy_d, done_d;

    assign o_State     = state_q;
    assign abort_now   = i_Abort && (state_q != IDLE);
    assign len_clamped = (i_Length > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : i_Length;
    assign last_step   = (LEN_W'(step_q) == (len_q - LEN_W'(1)));

    phase_timer #(.W(TMR_W)) u_timer (
        .i_Clk      (i_Clk),
        .i_Reset    (i_Reset),
        .i_Clear    (tmr_clear),
        .i_Enable   (tmr_en),
        .i_Terminal (tmr_term),
        .o_Expired  (tmr_expired)
    );

    // Pattern writes only while fully idle (state and busy flag), so the
    // stored pattern cannot change under an active or finishing playback.
    always_ff @(posedge i_Clk) begin
        if (i_Wr_En && (state_q == IDLE) && !o_Busy) begin
            pattern[i_Wr_Addr] <= i_Wr_Data;
        end
    end

    // State, latched length and step index.
    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            state_q <= IDLE;
            len_q   <= '0;
            step_q  <= '0;
        end else begin
            state_q <= state_d;
            if (load_len) begin
                len_q  <= len_clamped;
                step_q <= '0;
            end else if (step_inc) begin
                step_q <= step_q + STEP_W'(1);
            end
        end
    end

    // Next-state and timer control; abort overrides every other transition.
    always_comb begin
        state_d   = state_q;
        tmr_clear = 1'b0;
        tmr_en    = 1'b0;
        tmr_term  = ON_TERM;
        load_len  = 1'b0;
        step_inc  = 1'b0;
        if (abort_now) begin
            state_d   = IDLE;
            tmr_clear = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    tmr_clear = 1'b1;
                    if (i_Start) begin
                        load_len = 1'b1;
                        state_d  = LOAD;
                    end
                end
                LOAD: begin
                    tmr_clear = 1'b1;
                    state_d   = (len_q == '0) ? DONE : ON;
                end
                ON: begin
                    tmr_en   = 1'b1;
                    tmr_term = ON_TERM;
                    if (tmr_expired) state_d = GAP;
                end
                GAP: begin
                    tmr_en   = 1'b1;
                    tmr_term = GAP_TERM;
                    if (tmr_expired) begin
                        if (last_step) begin
                            state_d = DONE;
                        end else begin
                            step_inc = 1'b1;
                            state_d  = ON;
                        end
                    end
                end
                DONE: begin
                    tmr_clear = 1'b1;
                    state_d   = IDLE;
                end
                default: begin
                    tmr_clear = 1'b1;
                    state_d   = IDLE;
                end
            endcase
        end
    end

    // Output values derived from the current state, blanked on abort.
    always_comb begin
        led_d  = '0;
        busy_d = 1'b0;
        done_d = 1'b0;
        if (!abort_now) begin
            if (state_q == ON) led_d = colour_one_hot(pattern[step_q]);
            busy_d = (state_q != IDLE);
            done_d = (state_q == DONE);
        end
    end

    // Registered outputs.
    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            o_LED  <= '0;
            o_Busy <= 1'b0;
            o_Done <= 1'b0;
        end else begin
            o_LED  <= led_d;
            o_Busy <= busy_d;
            o_Done <= done_d;
        end
    end

endmodule
